// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and types for the pipelined carry-lookahead adder
// Purpose: group width and the packed per-group propagate/generate/sum record.
// Ports: none (package).
package cla_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic [CLA_GROUP_W-1:0] p;
    logic [CLA_GROUP_W-1:0] g;
    logic [CLA_GROUP_W-1:0] sum;
  } cla_grp_t;

endpackage

// File: rtl/cla4_group.sv
// rtl/cla4_group.sv - combinational 4-bit carry-lookahead group with group G/P
// Purpose: one 4-bit slice of the adder; all internal carries are flat lookahead terms.
// Ports:
//   a, b   - 4-bit operand slices
//   cin    - carry into the group
//   res    - bit propagate, bit generate and sum of the group
//   grp_g  - group generate (independent of cin)
//   grp_p  - group propagate (independent of cin)
module cla4_group
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   cin,
  output cla_grp_t               res,
  output logic                   grp_g,
  output logic                   grp_p
);

  logic [CLA_GROUP_W-1:0] p;
  logic [CLA_GROUP_W-1:0] g;
  logic [CLA_GROUP_W-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  // Group G/P are kept off the cin path so the upper lookahead level never loops back.
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

  assign res.p   = p;
  assign res.g   = g;
  assign res.sum = p ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - STAGES-deep pipelined carry-lookahead adder with valid/ready flow control
// Purpose: {cout,sum} = a + b_eff + cin_eff over STAGES register stages, plus signed overflow.
// Optional feature macro: CLA_SUB_EN adds the sub port (a - b when sub=1).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid, in_ready    - input handshake (in_ready = pipeline advances this cycle)
//   a, b, cin, [sub]      - operands, carry-in, optional subtract select
//   out_valid, out_ready  - output handshake
//   sum, cout, ovf        - result, carry out of MSB, signed overflow
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG  = WIDTH / CLA_GROUP_W;
  localparam int GPS = NG / STAGES;
  localparam int SW  = GPS * CLA_GROUP_W;
  localparam int NP  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int L   = STAGES - 1;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CLA_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Inter-stage registers: entry k feeds stage k+1.
  logic [WIDTH-1:0]  pa_q [NP];
  logic [WIDTH-1:0]  pa_d [NP];
  logic [WIDTH-1:0]  pb_q [NP];
  logic [WIDTH-1:0]  pb_d [NP];
  logic [WIDTH-1:0]  ps_q [NP];
  logic [WIDTH-1:0]  ps_d [NP];
  logic [NP-1:0]     pc_q, pc_d;
  logic [NP-1:0]     pv_q, pv_d;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // Stage inputs: stage 0 from the ports, later stages from the registers.
  logic [WIDTH-1:0]  st_a  [STAGES];
  logic [WIDTH-1:0]  st_b  [STAGES];
  logic [WIDTH-1:0]  st_s  [STAGES];
  logic [WIDTH-1:0]  st_ns [STAGES];
  logic [STAGES-1:0] st_c, st_v;

  always_comb begin
    st_a[0] = a;
    st_b[0] = b_eff;
    st_s[0] = '0;
    st_c    = '0;
    st_v    = '0;
    st_c[0] = cin_eff;
    st_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = pa_q[k-1];
      st_b[k] = pb_q[k-1];
      st_s[k] = ps_q[k-1];
      st_c[k] = pc_q[k-1];
      st_v[k] = pv_q[k-1];
    end
  end

  cla_grp_t          grp_res [NG];
  logic [NG-1:0]     grp_g, grp_p, grp_cin;
  logic [WIDTH-1:0]  grp_sum;
  logic [STAGES-1:0] stg_co;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla4_group u_grp (
      .a     (st_a[gi/GPS][gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .b     (st_b[gi/GPS][gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin   (grp_cin[gi]),
      .res   (grp_res[gi]),
      .grp_g (grp_g[gi]),
      .grp_p (grp_p[gi])
    );
    assign grp_sum[gi*CLA_GROUP_W +: CLA_GROUP_W] = grp_res[gi].sum;
  end

  // Group-level lookahead inside each stage, expanded as sum-of-products:
  // c_j = cin & P_0..P_{j-1}  |  OR_i ( G_i & P_{i+1}..P_{j-1} ).  j == GPS is the stage carry out.
  always_comb begin
    logic cj;
    logic t;
    cj      = 1'b0;
    t       = 1'b0;
    grp_cin = '0;
    stg_co  = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = 0; j <= GPS; j++) begin
        cj = st_c[k];
        for (int m = 0; m < j; m++) cj = cj & grp_p[k*GPS+m];
        for (int i = 0; i < j; i++) begin
          t = grp_g[k*GPS+i];
          for (int m = i + 1; m < j; m++) t = t & grp_p[k*GPS+m];
          cj = cj | t;
        end
        if (j < GPS) grp_cin[k*GPS+j] = cj;
        else         stg_co[k]        = cj;
      end
    end
  end

  // Merge this stage's slice into the running sum carried down the pipe.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_ns[k]            = st_s[k];
      st_ns[k][k*SW +: SW] = grp_sum[k*SW +: SW];
    end
  end

  logic adv;
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    pa_d        = pa_q;
    pb_d        = pb_q;
    ps_d        = ps_q;
    pc_d        = pc_q;
    pv_d        = pv_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pa_d[k] = st_a[k];
        pb_d[k] = st_b[k];
        ps_d[k] = st_ns[k];
        pc_d[k] = stg_co[k];
        pv_d[k] = st_v[k];
      end
      out_valid_d = st_v[L];
      sum_d       = st_ns[L];
      cout_d      = stg_co[L];
      ovf_d       = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) &&
                    (st_ns[L][WIDTH-1] != st_a[L][WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NP; k++) begin
        pa_q[k] <= '0;
        pb_q[k] <= '0;
        ps_q[k] <= '0;
      end
      pc_q        <= '0;
      pv_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      ps_q        <= ps_d;
      pc_q        <= pc_d;
      pv_q        <= pv_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL have parameter STAGES, default 2, number of register stages; legal values are 1 to WIDTH/4, and WIDTH/4 SHALL divide evenly by STAGES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands present this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH each: operands.
REQ-008 SHALL have port cin, input, 1: carry-in.
REQ-009 SHALL have port sub, input, 1: subtract mode; present only when CLA_SUB_EN is defined.
REQ-010 SHALL have port out_valid, output, 1: a result is held on the outputs.
REQ-011 SHALL have port out_ready, input, 1: the downstream side takes the result.
REQ-012 SHALL have port sum, output, WIDTH: result.
REQ-013 SHALL have port cout, output, 1: carry out of the MSB.
REQ-014 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-015 SHALL split the operands into WIDTH/4 groups of 4 bits; each group computes its sum with carry lookahead (generate g=a&b, propagate p=a^b, internal carries with no ripple).
REQ-016 SHALL assign groups to stages in equal contiguous slices, LSB slice first; within a stage, group carries SHALL be formed by group-level lookahead (group G/P), not by ripple.
REQ-017 SHALL register the carry out of each stage together with the not-yet-added upper operand bits and the already-computed lower sum bits, and pass them to the next stage.
REQ-018 SHALL have a latency of exactly STAGES cycles from an accepted input (in_valid and in_ready high) to out_valid with the matching result.
REQ-019 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-020 SHALL set ovf = (a[MSB] == b_eff[MSB]) and (sum[MSB] != a[MSB]), where b_eff is the b operand as used by the adder.
REQ-021 SHALL advance the whole pipeline when adv = !out_valid or out_ready, and SHALL hold every stage unchanged otherwise.
REQ-022 SHALL drive in_ready = adv, combinationally.
REQ-023 SHALL carry a valid bit in each stage; bubbles travel through the pipeline and are not collapsed.
REQ-024 SHALL hold sum, cout, ovf and out_valid stable while out_valid is high and out_ready is low.
REQ-025 SHALL deliver results in input order, with no loss or duplication, under any in_valid/out_ready pattern.
REQ-026 When in_valid is low in an advancing cycle, SHALL load a bubble (valid 0) into the first stage; data registers may take any value in that case.

Reset
REQ-027 SHALL, while rst_n is low, clear every stage valid bit, out_valid, sum, cout, ovf and all data and carry registers to 0, asynchronously.
REQ-028 SHALL discard any transaction in flight when reset is asserted mid-operation; the first result after reset SHALL come from the first input accepted after release.
REQ-029 SHALL drive in_ready high during reset and in the first cycle after release, since out_valid is 0.

Configuration
REQ-030 With CLA_SUB_EN defined, SHALL compute sum = a + ~b + 1 when sub=1, ignoring cin; b_eff = ~b; cout=1 means no borrow.
REQ-031 With CLA_SUB_EN undefined, SHALL omit the sub port and the inversion logic; b_eff = b.

Structure
REQ-032 SHALL take from shared package cla_pkg the constant CLA_GROUP_W = 4 and the packed struct type for a group's p/g/sum.
REQ-033 SHALL instantiate one sub-module, cla4_group, per group (4-bit lookahead adder with group G/P outputs); cla4_group SHALL be purely combinational.

Verification
REQ-034 SHALL cover, with WIDTH=16 and STAGES=2: a=0x0006, b=0x0002, cin=0 -> sum=0x0008, cout=0, ovf=0, out_valid exactly 2 cycles after acceptance.
REQ-035 SHALL cover full carry chain: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0; and a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
REQ-036 SHALL cover signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0.
REQ-037 SHALL cover back-pressure: stream 4 back-to-back inputs, then hold out_ready=0 for 3 cycles -> in_ready low while stalled, output held, all 4 results delivered in order.
REQ-038 SHALL cover reset mid-stream: pulse rst_n low with 2 items in flight -> out_valid=0 immediately, neither item is emitted, and the next input yields the correct result.
REQ-039 SHALL cover, with CLA_SUB_EN defined: sub=1, a=0x0003, b=0x000A -> sum=0xFFF9, cout=0; repeat the last two checks with WIDTH=64, STAGES=4 against a reference model.
